// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable controller on the board clock domain.
// Generates two single-cycle phase enables (phase1_en, phase2_en) in four modes:
// manual single-step, manual burst, slow run and fast run. Also debounces the
// step button and exports the free-running prescaler.
//
// Ports:
//   clk        board clock
//   rst        synchronous reset, active-high
//   mode       00 manual step, 01 manual burst, 10 slow run, 11 fast run
//   button     raw step button, active-high, asynchronous
//   burst_len  steps per burst, sampled on press
//   halt       stop at the next step boundary
//   phase1_en  single-cycle enable, first half of a CPU step
//   phase2_en  single-cycle enable, second half of a CPU step
//   busy       step/burst pending or phase mid-step
//   burst_left remaining burst steps
//   button_db  debounced button level
//   div_out    free-running prescaler
module cpu_clock_ctrl #(
  parameter int unsigned DIV_WIDTH   = 18,
  parameter int unsigned SLOW_BIT    = 15,
  parameter int unsigned FAST_BIT    = 6,
  parameter int unsigned DEB_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   button,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   halt,
  output logic                   phase1_en,
  output logic                   phase2_en,
  output logic                   busy,
  output logic [BURST_WIDTH-1:0] burst_left,
  output logic                   button_db,
  output logic [DIV_WIDTH-1:0]   div_out
);

  localparam logic [1:0] ModeStep  = 2'b00;
  localparam logic [1:0] ModeBurst = 2'b01;
  localparam logic [1:0] ModeSlow  = 2'b10;
  localparam logic [1:0] ModeFast  = 2'b11;

  typedef enum logic {StPh0, StPh1} phase_e;

  logic [DIV_WIDTH-1:0]   div_q;
  logic [1:0]             sync_q;
  logic [DEB_WIDTH-1:0]   deb_cnt_q, deb_cnt_d;
  logic                   button_db_q, button_db_d;
  logic                   press_q, press_d;
  logic [1:0]             mode_q;
  phase_e                 phase_q, phase_d;
  logic                   p1_q, p1_d, p2_q, p2_d;
  logic                   pending_q, pending_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;

  logic slow_tick, fast_tick, fire_start, fire_end, step_done, mode_chg;

  assign slow_tick = &div_q[SLOW_BIT:0];
  assign fast_tick = &div_q[FAST_BIT:0];
  assign mode_chg  = (mode != mode_q);

  assign busy       = pending_q | (burst_q != '0) | (phase_q == StPh1);
  assign phase1_en  = p1_q;
  assign phase2_en  = p2_q;
  assign burst_left = burst_q;
  assign button_db  = button_db_q;
  assign div_out    = div_q;

  // Debouncer: count while the synchronised level disagrees with the debounced one.
  always_comb begin
    deb_cnt_d   = '0;
    button_db_d = button_db_q;
    if (sync_q[1] != button_db_q) begin
      if (&deb_cnt_q) begin
        button_db_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    // Registered, so press_q is high in the first cycle button_db reads 1.
    press_d = button_db_d & ~button_db_q;
  end

  // Phase FSM and step bookkeeping.
  always_comb begin
    fire_start = 1'b0;
    unique case (mode)
      ModeStep:  fire_start = pending_q & fast_tick;
      ModeBurst: fire_start = (burst_q != '0) & slow_tick;
      ModeSlow:  fire_start = slow_tick;
      ModeFast:  fire_start = fast_tick;
    endcase
    fire_start = fire_start & ~halt;

    // Slow run keeps the half-step spacing at the slow rate; in every other case
    // (including halt or a mode switch mid-step) the step is closed on the next
    // fast tick so the CPU is never parked between phases.
    fire_end = ((mode == ModeSlow) && !halt) ? slow_tick : fast_tick;

    phase_d   = phase_q;
    p1_d      = 1'b0;
    p2_d      = 1'b0;
    step_done = 1'b0;
    unique case (phase_q)
      StPh0: begin
        if (fire_start) begin
          phase_d = StPh1;
          p1_d    = 1'b1;
        end
      end
      StPh1: begin
        if (fire_end) begin
          phase_d   = StPh0;
          p2_d      = 1'b1;
          step_done = 1'b1;
        end
      end
    endcase

    pending_d = pending_q;
    burst_d   = burst_q;
    // Completion wins over a simultaneous press (which is also masked by busy).
    if (step_done) begin
      pending_d = 1'b0;
      if (burst_q != '0) burst_d = burst_q - 1'b1;
    end else if (press_q && !busy) begin
      if (mode == ModeStep)  pending_d = 1'b1;
      if (mode == ModeBurst) burst_d   = burst_len;
    end
    if (mode_chg) begin
      pending_d = 1'b0;
      burst_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      sync_q      <= '0;
      deb_cnt_q   <= '0;
      button_db_q <= 1'b0;
      press_q     <= 1'b0;
      mode_q      <= ModeStep;
      phase_q     <= StPh0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      pending_q   <= 1'b0;
      burst_q     <= '0;
    end else begin
      div_q       <= div_q + 1'b1;
      sync_q      <= {sync_q[0], button};
      deb_cnt_q   <= deb_cnt_d;
      button_db_q <= button_db_d;
      press_q     <= press_d;
      mode_q      <= mode;
      phase_q     <= phase_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      pending_q   <= pending_d;
      burst_q     <= burst_d;
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
module tb_cpu_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       button = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       halt = 1'b0;
  logic       phase1_en, phase2_en, busy, button_db;
  logic [7:0] burst_left;
  logic [9:0] div_out;

  cpu_clock_ctrl #(
    .DIV_WIDTH  (10),
    .SLOW_BIT   (5),
    .FAST_BIT   (2),
    .DEB_WIDTH  (3),
    .BURST_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .button    (button),
    .burst_len (burst_len),
    .halt      (halt),
    .phase1_en (phase1_en),
    .phase2_en (phase2_en),
    .busy      (busy),
    .burst_left(burst_left),
    .button_db (button_db),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  // Expected enable: kind (1/2), gap to previous enable (0 = unchecked),
  // alignment period of the cycle count, expected burst_left (-1 = unchecked).
  typedef struct {
    int kind;
    int gap;
    int align;
    int bl;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_en = 0;

  // Cycle count since reset release; the prescaler must track it modulo 1024.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int gap, input int align, input int bl);
    exp_t e;
    e.kind  = kind;
    e.gap   = gap;
    e.align = align;
    e.bl    = bl;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d enables outstanding after %0d cycles, expected 0",
               name, sb.size(), budget);
      sb.delete();
    end
  endtask

  // Monitor: prescaler tracking and scoreboard comparison of every enable.
  always @(negedge clk) begin
    if (!rst) begin
      logic [9:0] exp_div;
      exp_div = cyc[9:0];
      chk("div_out", int'(div_out), int'(exp_div));
      if (phase1_en && phase2_en) chk("both_enables", 1, 0);
      if (phase1_en || phase2_en) begin
        int kind;
        kind = phase1_en ? 1 : 2;
        if (sb.size() == 0) begin
          chk("unexpected_enable_kind", kind, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("enable_kind", kind, e.kind);
          if (e.gap != 0) chk("enable_gap", cyc - last_en, e.gap);
          chk("enable_align", cyc % e.align, 0);
          if (e.bl >= 0) chk("burst_left", int'(burst_left), e.bl);
        end
        last_en = cyc;
      end
    end
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_phase1_en", int'(phase1_en), 0);
    chk("rst_phase2_en", int'(phase2_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_burst_left", int'(burst_left), 0);
    chk("rst_button_db", int'(button_db), 0);
    chk("rst_div_out", int'(div_out), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Manual step with a bouncing button
    push(1, 0, 8, 0);
    push(2, 8, 8, 0);
    button = 1'b1; repeat (2) @(negedge clk);
    button = 1'b0; @(negedge clk);
    button = 1'b1; @(negedge clk);
    button = 1'b0; @(negedge clk);
    button = 1'b1; repeat (20) @(negedge clk);
    chk("db_high", int'(button_db), 1);
    button = 1'b0; repeat (20) @(negedge clk);
    chk("db_low", int'(button_db), 0);
    drain("manual_step", 100);
    chk("manual_busy", int'(busy), 0);
    repeat (20) @(negedge clk);

    // Burst of 3, second press ignored
    mode = 2'b01;
    burst_len = 8'd3;
    push(1, 0, 64, 3);
    push(2, 8, 8, 2);
    push(1, 56, 64, 2);
    push(2, 8, 8, 1);
    push(1, 56, 64, 1);
    push(2, 8, 8, 0);
    button = 1'b1; repeat (12) @(negedge clk);
    button = 1'b0; repeat (12) @(negedge clk);
    chk("burst_busy", int'(busy), 1);
    button = 1'b1; repeat (12) @(negedge clk);
    button = 1'b0; repeat (12) @(negedge clk);
    drain("burst", 400);
    chk("burst_done_busy", int'(busy), 0);
    chk("burst_done_left", int'(burst_left), 0);

    // Slow run, then switch to fast mid-step
    mode = 2'b10;
    push(1, 0, 64, 0);
    push(2, 64, 64, 0);
    push(1, 64, 64, 0);
    drain("slow_run", 300);
    push(2, 8, 8, 0);
    push(1, 8, 8, 0);
    push(2, 8, 8, 0);
    push(1, 8, 8, 0);
    push(2, 8, 8, 0);
    mode = 2'b11;
    drain("fast_run", 100);
    mode = 2'b00;
    repeat (30) @(negedge clk);

    // Halt after a phase1_en
    mode = 2'b11;
    push(1, 0, 8, 0);
    drain("halt_pre", 50);
    halt = 1'b1;
    push(2, 8, 8, 0);
    drain("halt_complete", 50);
    repeat (40) @(negedge clk);
    chk("halt_busy", int'(busy), 0);
    push(1, 0, 8, 0);
    #1 halt = 1'b0;
    drain("halt_release", 50);

    // Reset one cycle after phase1_en: phase2_en must never appear
    rst  = 1'b1;
    mode = 2'b00;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_phase2_en", int'(phase2_en), 0);
    chk("midrst_div_out", int'(div_out), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
